uart_cmd_bridge: RTL and testbench
==================================

# uart_cmd_bridge

Byte-level command responder between the UART byte interface and an 8-bit on-chip register bus. It consumes received bytes (`rx_data`/`rx_ok`) and decodes read and write commands from a host. It executes each command as a single register-bus access and returns exactly one response byte through the UART transmit handshake (`tx_data`/`tx_send`/`tx_busy`). It is the host-access path for debug and control registers in FPGA designs.

## Interface
- `TIMEOUT_CYCLES`, default 500000: idle cycles allowed between bytes of one command before the command is aborted (10 ms at 50 MHz).
- `ACK_BYTE`, default 8'h4B: response to a completed write.
- `NAK_BYTE`, default 8'h3F: response to an unknown opcode.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte. Valid only while `rx_ok` is high.
- `rx_ok` in 1: one-cycle strobe, one per received byte.
- `tx_data` out 8: response byte. Held stable from the `tx_send` cycle until the bridge returns to IDLE.
- `tx_send` out 1: one-cycle request to transmit `tx_data`.
- `tx_busy` in 1: transmitter busy. Rises the cycle after `tx_send` is sampled high and falls when the stop bit ends.
- `bus_addr` out 8: register address. Held from the address byte until the next command.
- `bus_wdata` out 8: write data.
- `bus_we` out 1: one-cycle write strobe.
- `bus_re` out 1: one-cycle read strobe.
- `bus_rdata` in 8: read data. Valid on the cycle after `bus_re`.
- `busy` out 1: high in every state except IDLE.
- `cmd_err` out 1: one-cycle pulse on an unknown opcode, an inter-byte timeout, or a byte dropped during a response.

## Operation
- Command formats:
  - Write: 8'h57 ('W'), addr, data → reply `ACK_BYTE`.
  - Read: 8'h52 ('R'), addr → reply `bus_rdata`.
  - Any other first byte → reply `NAK_BYTE`.
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAP, TX_REQ, TX_WAIT.
- IDLE:
  - `rx_ok` with 'W' or 'R' → GET_ADDR, with the opcode latched.
  - `rx_ok` with any other byte → TX_REQ, `tx_data`=`NAK_BYTE`, `cmd_err` pulse.
- GET_ADDR, on `rx_ok`:
  - latch `bus_addr`;
  - go to GET_DATA if the opcode is 'W', otherwise BUS_RD.
- GET_DATA, on `rx_ok`: latch `bus_wdata` → BUS_WR.
- BUS_WR: `bus_we`=1 for this cycle only; `tx_data`=`ACK_BYTE` → TX_REQ.
- BUS_RD: `bus_re`=1 for this cycle only → RD_CAP.
- RD_CAP: `tx_data` ← `bus_rdata` → TX_REQ.
- TX_REQ:
  - if `tx_busy`=0: `tx_send`=1 for one cycle → TX_WAIT;
  - otherwise stay in TX_REQ.
- TX_WAIT: when `tx_busy`=0 → IDLE. This is first sampled the cycle after `tx_send`, when `tx_busy` is already high.
- Timeout counter:
  - Runs only in GET_ADDR and GET_DATA; cleared on every `rx_ok` and on entry to those states.
  - Width is ceil(log2(TIMEOUT_CYCLES+1)) bits and the counter never wraps.
  - When it reaches `TIMEOUT_CYCLES` → IDLE, `cmd_err` pulse, no bus access, no response.
- Bytes in other states: an `rx_ok` in BUS_WR, BUS_RD, RD_CAP, TX_REQ or TX_WAIT is discarded and pulses `cmd_err`. The state is unaffected.
- Simultaneous events:
  - Timeout expiry and `rx_ok` in the same cycle: the byte wins and the counter clears.
  - `cmd_err` pulses from two sources in the same cycle merge into a single one-cycle pulse.
- Reset mid-command: all state is lost, with no bus strobe and no `tx_send` until a new command arrives.

## Timing
- Reset values: `tx_data`=0, `tx_send`=0, `bus_addr`=0, `bus_wdata`=0, `bus_we`=0, `bus_re`=0, `busy`=0, `cmd_err`=0, state=IDLE, counter=0.
- All outputs are registered, with no combinational path from any input to any output.
- Write, with the data-byte `rx_ok` at cycle N:
  - `bus_we` at N+1;
  - `tx_send` at N+2 if `tx_busy` is low.
- Read, with the address-byte `rx_ok` at cycle N:
  - `bus_re` at N+1;
  - `bus_rdata` sampled at N+2;
  - `tx_send` at N+3.
- NAK, with the opcode `rx_ok` at N: `cmd_err` and TX_REQ at N+1, `tx_send` at N+1 if `tx_busy` is low.
- Back-to-back commands are accepted only after TX_WAIT has exited to IDLE.

## Test plan
- Write: bytes 57,10,A5 → one `bus_we` pulse with `bus_addr`=10, `bus_wdata`=A5, exactly one cycle after the third `rx_ok`; then `tx_send` with `tx_data`=4B.
- Read: bytes 52,3C with the bus model returning 5A → `bus_re` at N+1 with `bus_addr`=3C, `tx_send` at N+3 with `tx_data`=5A; `busy` falls after `tx_busy` falls.
- Unknown opcode: byte 41 → `cmd_err` pulse, `tx_send` with `tx_data`=3F, no bus strobe.
- Timeout: byte 57, then silence for `TIMEOUT_CYCLES` (set to 100 in the bench) → `cmd_err` at cycle 100 and return to IDLE, no strobe, no `tx_send`. A following 52,01 then works normally.
- Backpressure and drop: `tx_busy` held high for 50 cycles at TX_REQ → `tx_send` is delayed until it falls. An `rx_ok` during TX_WAIT → `cmd_err` pulse, with the response and state unaffected.
- Reset: `rst_n` asserted between the address and data bytes of a write → all outputs 0, no `bus_we`; the next command executes correctly.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// uart_cmd_bridge: decodes 'W'/'R' byte commands from a UART receiver,
// performs one register-bus access per command and returns one response byte.
module uart_cmd_bridge #(
    parameter int         TIMEOUT_CYCLES = 500000,
    parameter logic [7:0] ACK_BYTE       = 8'h4B,
    parameter logic [7:0] NAK_BYTE       = 8'h3F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_ok,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_busy,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic [7:0] bus_rdata,
    output logic       busy,
    output logic       cmd_err
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [7:0]       OP_WRITE = 8'h57;
    localparam logic [7:0]       OP_READ  = 8'h52;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        BUS_WR,
        BUS_RD,
        RD_CAP,
        TX_REQ,
        TX_WAIT
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             op_write;
    logic             op_write_nxt;
    logic [CNT_W-1:0] count;
    logic [7:0]       tx_data_nxt;
    logic [7:0]       bus_addr_nxt;
    logic [7:0]       bus_wdata_nxt;
    logic             err_nxt;

    // State and latched-opcode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_write <= 1'b0;
        end else begin
            state    <= next_state;
            op_write <= op_write_nxt;
        end
    end

    // Next-state decode plus the next value of every registered output.
    always_comb begin
        next_state    = state;
        op_write_nxt  = op_write;
        tx_data_nxt   = tx_data;
        bus_addr_nxt  = bus_addr;
        bus_wdata_nxt = bus_wdata;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ok) begin
                    if ((rx_data == OP_WRITE) || (rx_data == OP_READ)) begin
                        next_state   = GET_ADDR;
                        op_write_nxt = (rx_data == OP_WRITE);
                    end else begin
                        next_state  = TX_REQ;
                        tx_data_nxt = NAK_BYTE;
                        err_nxt     = 1'b1;
                    end
                end
            end
            GET_ADDR: begin
                if (rx_ok) begin
                    bus_addr_nxt = rx_data;
                    next_state   = op_write ? GET_DATA : BUS_RD;
                end else if (count >= CNT_LAST) begin
                    next_state = IDLE;
                    err_nxt    = 1'b1;
                end
            end
            GET_DATA: begin
                if (rx_ok) begin
                    bus_wdata_nxt = rx_data;
                    next_state    = BUS_WR;
                end else if (count >= CNT_LAST) begin
                    next_state = IDLE;
                    err_nxt    = 1'b1;
                end
            end
            BUS_WR: begin
                tx_data_nxt = ACK_BYTE;
                next_state  = TX_REQ;
                err_nxt     = rx_ok;
            end
            BUS_RD: begin
                next_state = RD_CAP;
                err_nxt    = rx_ok;
            end
            RD_CAP: begin
                tx_data_nxt = bus_rdata;
                next_state  = TX_REQ;
                err_nxt     = rx_ok;
            end
            TX_REQ: begin
                if (tx_send) begin
                    next_state = TX_WAIT;
                end
                err_nxt = rx_ok;
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    next_state = IDLE;
                end
                err_nxt = rx_ok;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered outputs; strobes are derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data   <= 8'h00;
            tx_send   <= 1'b0;
            bus_addr  <= 8'h00;
            bus_wdata <= 8'h00;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            tx_data   <= tx_data_nxt;
            tx_send   <= (next_state == TX_REQ) && !tx_busy;
            bus_addr  <= bus_addr_nxt;
            bus_wdata <= bus_wdata_nxt;
            bus_we    <= (next_state == BUS_WR);
            bus_re    <= (next_state == BUS_RD);
            busy      <= (next_state != IDLE);
            cmd_err   <= err_nxt;
        end
    end

    // Inter-byte idle counter; cleared by any byte or state change, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (rx_ok || (next_state != state) ||
                     !((state == GET_ADDR) || (state == GET_DATA))) begin
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench for uart_cmd_bridge with a register-file bus model and a
// simple UART transmitter model.
module tb_uart_cmd_bridge;

    localparam int TIMEOUT = 100;
    localparam int TX_LEN  = 10;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       rx_ok     = 1'b0;
    logic [7:0] tx_data;
    logic       tx_send;
    logic       tx_busy;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic [7:0] bus_rdata = 8'h00;
    logic       busy;
    logic       cmd_err;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       exp_wr[$];
    exp_t       exp_rd[$];
    exp_t       exp_tx[$];
    logic [7:0] bus_mem[256];
    logic [7:0] exp_mem[256];

    int   cyc          = 0;
    int   total        = 0;
    int   bad          = 0;
    int   err_count    = 0;
    int   last_err_cyc = -1;
    int   tx_count     = 0;
    int   last_tx_cyc  = -1;
    int   tx_cnt       = 0;
    logic hold_busy    = 1'b0;

    assign tx_busy = (tx_cnt != 0) || hold_busy;

    uart_cmd_bridge #(
        .TIMEOUT_CYCLES(TIMEOUT),
        .ACK_BYTE      (8'h4B),
        .NAK_BYTE      (8'h3F)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_ok    (rx_ok),
        .tx_data  (tx_data),
        .tx_send  (tx_send),
        .tx_busy  (tx_busy),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we   (bus_we),
        .bus_re   (bus_re),
        .bus_rdata(bus_rdata),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp observed events.
    always @(posedge clk) cyc <= cyc + 1;

    // Register-file bus: read data appears the cycle after bus_re.
    always @(posedge clk) begin
        if (bus_we) bus_mem[bus_addr] <= bus_wdata;
        if (bus_re) bus_rdata <= bus_mem[bus_addr];
    end

    // Transmitter: busy from the cycle after tx_send for TX_LEN cycles.
    always @(posedge clk) begin
        if (tx_send) tx_cnt <= TX_LEN;
        else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT produces a strobe or response.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (bus_we) begin
                if (exp_wr.size() == 0) checkOutput("unexpected_bus_we", 32'd1, 32'd0);
                else begin
                    e = exp_wr.pop_front();
                    checkOutput("we_addr", bus_addr, e.addr);
                    checkOutput("we_data", bus_wdata, e.data);
                    if (e.cyc >= 0) checkOutput("we_cycle", cyc, e.cyc);
                end
            end
            if (bus_re) begin
                if (exp_rd.size() == 0) checkOutput("unexpected_bus_re", 32'd1, 32'd0);
                else begin
                    e = exp_rd.pop_front();
                    checkOutput("re_addr", bus_addr, e.addr);
                    if (e.cyc >= 0) checkOutput("re_cycle", cyc, e.cyc);
                end
            end
            if (tx_send) begin
                tx_count++;
                last_tx_cyc = cyc;
                if (exp_tx.size() == 0) checkOutput("unexpected_tx_send", 32'd1, 32'd0);
                else begin
                    e = exp_tx.pop_front();
                    checkOutput("tx_data", tx_data, e.data);
                    if (e.cyc >= 0) checkOutput("tx_cycle", cyc, e.cyc);
                end
            end
            if (cmd_err) begin
                err_count++;
                last_err_cyc = cyc;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_ok   = 1'b1;
        @(negedge clk);
        rx_ok   = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, busy, 1'b0);
        checkOutput({tag, "_txbusy_low_at_idle"}, tx_busy, 1'b0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tx_data"}, tx_data, 8'h00);
        checkOutput({tag, "_tx_send"}, tx_send, 1'b0);
        checkOutput({tag, "_bus_addr"}, bus_addr, 8'h00);
        checkOutput({tag, "_bus_wdata"}, bus_wdata, 8'h00);
        checkOutput({tag, "_bus_we"}, bus_we, 1'b0);
        checkOutput({tag, "_bus_re"}, bus_re, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_cmd_err"}, cmd_err, 1'b0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        int n;
        int r;
        int k;
        int err0;
        int tx0;

        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = 8'(i) ^ 8'h66;
            exp_mem[i] = 8'(i) ^ 8'h66;
        end
        bus_mem[8'h3C] = 8'h5A;
        exp_mem[8'h3C] = 8'h5A;

        repeat (3) @(negedge clk);
        checkResetOutputs("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 57,10,A5
        applyStimulus(8'h57);
        applyStimulus(8'h10);
        n = cyc + 1;
        exp_wr.push_back('{addr: 8'h10, data: 8'hA5, cyc: n + 1});
        exp_tx.push_back('{addr: 8'h00, data: 8'h4B, cyc: n + 2});
        exp_mem[8'h10] = 8'hA5;
        err0 = err_count;
        applyStimulus(8'hA5);
        waitIdle("wr");
        checkOutput("wr_no_err", err_count - err0, 0);

        // Read 52,3C
        applyStimulus(8'h52);
        n = cyc + 1;
        exp_rd.push_back('{addr: 8'h3C, data: 8'h00, cyc: n + 1});
        exp_tx.push_back('{addr: 8'h00, data: exp_mem[8'h3C], cyc: n + 3});
        applyStimulus(8'h3C);
        checkOutput("rd_busy", busy, 1'b1);
        k = 0;
        while (!tx_busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("rd_busy_while_tx", busy, 1'b1);
        waitIdle("rd");

        // Unknown opcode 41
        err0 = err_count;
        n = cyc + 1;
        exp_tx.push_back('{addr: 8'h00, data: 8'h3F, cyc: n + 1});
        applyStimulus(8'h41);
        waitIdle("nak");
        checkOutput("nak_err_cnt", err_count - err0, 1);
        checkOutput("nak_err_cyc", last_err_cyc, n + 1);

        // Timeout after opcode 57
        err0 = err_count;
        tx0  = tx_count;
        n    = cyc + 1;
        applyStimulus(8'h57);
        k = 0;
        while (err_count == err0 && k < TIMEOUT + 50) begin
            @(negedge clk);
            k++;
        end
        checkOutput("to_err_cyc", last_err_cyc, n + TIMEOUT + 1);
        checkOutput("to_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("to_err_cnt", err_count - err0, 1);
        checkOutput("to_no_tx", tx_count - tx0, 0);
        applyStimulus(8'h52);
        n = cyc + 1;
        exp_rd.push_back('{addr: 8'h01, data: 8'h00, cyc: n + 1});
        exp_tx.push_back('{addr: 8'h00, data: exp_mem[8'h01], cyc: n + 3});
        applyStimulus(8'h01);
        waitIdle("to_rd");

        // Backpressure then dropped byte during TX_WAIT
        hold_busy = 1'b1;
        applyStimulus(8'h57);
        applyStimulus(8'h22);
        n = cyc + 1;
        exp_wr.push_back('{addr: 8'h22, data: 8'hC3, cyc: n + 1});
        exp_tx.push_back('{addr: 8'h00, data: 8'h4B, cyc: -1});
        exp_mem[8'h22] = 8'hC3;
        tx0 = tx_count;
        applyStimulus(8'hC3);
        repeat (50) @(negedge clk);
        checkOutput("bp_held", tx_count - tx0, 0);
        checkOutput("bp_busy", busy, 1'b1);
        r = cyc;
        hold_busy = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("bp_tx_cyc", last_tx_cyc, r + 1);
        err0 = err_count;
        n = cyc + 1;
        applyStimulus(8'h99);
        @(negedge clk);
        checkOutput("drop_err_cnt", err_count - err0, 1);
        checkOutput("drop_err_cyc", last_err_cyc, n + 1);
        checkOutput("drop_busy", busy, 1'b1);
        waitIdle("bp");
        checkOutput("bp_tx_once", tx_count - tx0, 1);

        // Reset between address and data bytes of a write
        applyStimulus(8'h57);
        applyStimulus(8'h44);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("midrst_idle", busy, 1'b0);
        applyStimulus(8'h57);
        applyStimulus(8'h44);
        n = cyc + 1;
        exp_wr.push_back('{addr: 8'h44, data: 8'h77, cyc: n + 1});
        exp_tx.push_back('{addr: 8'h00, data: 8'h4B, cyc: n + 2});
        exp_mem[8'h44] = 8'h77;
        applyStimulus(8'h77);
        waitIdle("post_wr");
        applyStimulus(8'h52);
        n = cyc + 1;
        exp_rd.push_back('{addr: 8'h44, data: 8'h00, cyc: n + 1});
        exp_tx.push_back('{addr: 8'h00, data: exp_mem[8'h44], cyc: n + 3});
        applyStimulus(8'h44);
        waitIdle("post_rd");

        repeat (3) @(negedge clk);
        checkOutput("wr_queue_empty", exp_wr.size(), 0);
        checkOutput("rd_queue_empty", exp_rd.size(), 0);
        checkOutput("tx_queue_empty", exp_tx.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
